gpia_port: RTL and testbench

Parametrised general-purpose I/O port, the multi-bit successor to the single-bit GPIA output cell. It provides a WIDTH-bit output register with write/set/clear/toggle access modes, a synchronised input path with per-bit edge detection and a level interrupt output. It sits on the system Wishbone bus as a single-cycle-ack slave and drives board-level pins directly.

---
 rtl/gpia_pkg.sv | 38 +++
 rtl/gpia_sync.sv | 31 +++
 rtl/gpia_port.sv | 117 +++++++++++
 tb/tb_gpia_port.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpia_pkg.sv
// Shared definitions for the GPIA port family: register addresses, output modes, mode helper.
// Latency: none, declarations and a combinational helper only.
// Backpressure: not applicable.
package gpia_pkg;

  // Register map, selected by adr_i
  localparam logic [2:0] ADR_OUT_WR  = 3'd0;
  localparam logic [2:0] ADR_OUT_SET = 3'd1;
  localparam logic [2:0] ADR_OUT_CLR = 3'd2;
  localparam logic [2:0] ADR_OUT_TGL = 3'd3;
  localparam logic [2:0] ADR_IN      = 3'd4;
  localparam logic [2:0] ADR_IEN     = 3'd5;
  localparam logic [2:0] ADR_PEND    = 3'd6;
  localparam logic [2:0] ADR_POL     = 3'd7;

  // Output access modes; same encoding as the single-bit GPIA cell
  typedef enum logic [1:0] {
    MODE_WR  = 2'd0,
    MODE_SET = 2'd1,
    MODE_CLR = 2'd2,
    MODE_TGL = 2'd3
  } mode_t;

  // Apply an access mode to the current register value q with data/mask d.
  // Works on 32 bits; narrower ports zero-extend in and truncate out.
  function automatic logic [31:0] apply_mode(input mode_t mode,
                                             input logic [31:0] q,
                                             input logic [31:0] d);
    case (mode)
      MODE_WR:  apply_mode = d;
      MODE_SET: apply_mode = q | d;
      MODE_CLR: apply_mode = q & ~d;
      MODE_TGL: apply_mode = q ^ d;
      default:  apply_mode = q;
    endcase
  endfunction

endpackage

// File: rtl/gpia_sync.sv
// Pin input synchroniser: SYNC_STAGES flops deep, plus one more flop holding the previous value.
// Latency: sync is SYNC_STAGES cycles behind pin_i, prev one cycle behind sync.
// Backpressure: none, free-running every cycle.
module gpia_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             res_i,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] prev
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  // Shift the raw pins through the stage chain; the last stage feeds prev
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      prev <= '0;
    end else begin
      stage[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      prev <= stage[SYNC_STAGES-1];
    end
  end

  assign sync = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpia_port.sv
// WIDTH-bit GPIO port: mode-addressed output register, synchronised inputs with edge pending, level irq.
// Latency: writes commit on the accepting edge, read data/ack one cycle later; pin->PEND SYNC_STAGES+1, pin->irq SYNC_STAGES+2.
// Backpressure: single-cycle ack; a held strobe is accepted at most every second cycle.
module gpia_port
  import gpia_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             res_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [2:0]       adr_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             ack_o,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] q_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] ien;
  logic [WIDTH-1:0] pol;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] rdat;
  logic             ack;
  logic             irq;
  logic             accept;
  logic             wr;

  gpia_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .res_i (res_i),
    .pin_i (pin_i),
    .sync  (sync),
    .prev  (prev)
  );

  // The ack cycle itself never accepts, which spaces back-to-back accesses two cycles apart
  assign accept = stb_i & ~ack;
  assign wr     = accept & we_i;

  // Per-bit edge qualified by polarity; a POL change alone never looks like an edge
  // because only sync vs prev is compared
  always_comb begin
    edge_det = (pol & sync & ~prev) | (~pol & ~sync & prev);
    clr_mask = (wr && adr_i == ADR_PEND) ? dat_i : '0;
  end

  // Read data select; all four output-mode addresses read back q
  always_comb begin
    rd_mux = '0;
    case (adr_i)
      ADR_IN:   rd_mux = sync;
      ADR_IEN:  rd_mux = ien;
      ADR_PEND: rd_mux = pend;
      ADR_POL:  rd_mux = pol;
      default:  rd_mux = q;
    endcase
  end

  // Bus handshake: one-cycle ack, read data held only for the ack cycle
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      ack  <= 1'b0;
      rdat <= '0;
    end else begin
      ack  <= accept;
      rdat <= (accept && !we_i) ? rd_mux : '0;
    end
  end

  // Output and configuration registers; writes to IN fall through and are ignored
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      q   <= '0;
      ien <= '0;
      pol <= '0;
    end else if (wr) begin
      case (adr_i)
        ADR_OUT_WR, ADR_OUT_SET, ADR_OUT_CLR, ADR_OUT_TGL:
          q <= WIDTH'(apply_mode(mode_t'(adr_i[1:0]), 32'(q), 32'(dat_i)));
        ADR_IEN: ien <= dat_i;
        ADR_POL: pol <= dat_i;
        default: ;
      endcase
    end
  end

  // Pending bits: write-1-to-clear, with a same-cycle edge taking priority over the clear
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) pend <= '0;
    else        pend <= (pend & ~clr_mask) | edge_det;
  end

  // Registered level interrupt from enabled pending bits
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) irq <= 1'b0;
    else        irq <= |(pend & ien);
  end

  assign dat_o = rdat;
  assign ack_o = ack;
  assign q_o   = q;
  assign irq_o = irq;

endmodule

// File: tb/tb_gpia_port.sv
// Self-checking bench for gpia_port at WIDTH=8: directed scenarios then randomized bus/pin traffic
// checked against a transaction-level model of the register semantics.
module tb_gpia_port;
  import gpia_pkg::*;

  localparam int W  = 8;
  localparam int SS = 2;

  logic         clk   = 1'b0;
  logic         res_n = 1'b0;
  logic         stb   = 1'b0;
  logic         we    = 1'b0;
  logic [2:0]   adr   = 3'd0;
  logic [W-1:0] dat   = '0;
  logic [W-1:0] pins  = '0;
  logic [W-1:0] dat_o;
  logic         ack;
  logic [W-1:0] q;
  logic         irq;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] rd;

  gpia_port #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk_i (clk),
    .res_i (res_n),
    .stb_i (stb),
    .we_i  (we),
    .adr_i (adr),
    .dat_i (dat),
    .dat_o (dat_o),
    .ack_o (ack),
    .pin_i (pins),
    .q_o   (q),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge
  task automatic bus_start(input logic w, input logic [2:0] a, input logic [W-1:0] d);
    check_bit("ack_before_accept", ack, 1'b0);
    stb = 1'b1; we = w; adr = a; dat = d;
    @(posedge clk); #1;
    check_bit("ack_after_accept", ack, 1'b1);
    rd  = dat_o;
    stb = 1'b0; we = 1'b0; dat = '0;
  endtask

  task automatic bus_end();
    @(posedge clk); #1;
    check_bit("ack_one_cycle", ack, 1'b0);
    check_vec("dat_o_idle", dat_o, '0);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [W-1:0] d);
    bus_start(1'b1, a, d);
    bus_end();
  endtask

  task automatic bus_read(input string tag, input logic [2:0] a, input logic [W-1:0] exp);
    bus_start(1'b0, a, '0);
    bus_end();
    check_vec(tag, rd, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transaction-level reference state for the random phase
  logic [W-1:0] m_q, m_ien, m_pol, m_pend, m_pins;
  logic [W-1:0] wr_dat [4];
  logic [W-1:0] q_exp  [4];

  initial begin
    // ---- reset values
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_q", q, 8'h00);
    check_bit("reset_irq", irq, 1'b0);
    check_bit("reset_ack", ack, 1'b0);
    check_vec("reset_dat_o", dat_o, 8'h00);
    res_n = 1'b1;
    cycles(1);
    bus_read("rd_reset_out", ADR_OUT_WR, 8'h00);
    bus_read("rd_reset_in", ADR_IN, 8'h00);
    bus_read("rd_reset_ien", ADR_IEN, 8'h00);
    bus_read("rd_reset_pend", ADR_PEND, 8'h00);
    bus_read("rd_reset_pol", ADR_POL, 8'h00);

    // ---- output access modes, q visible right after the accepting edge
    wr_dat[0] = 8'hA5; wr_dat[1] = 8'h0F; wr_dat[2] = 8'h81; wr_dat[3] = 8'hFF;
    q_exp[0]  = 8'hA5; q_exp[1]  = 8'hAF; q_exp[2]  = 8'h2E; q_exp[3]  = 8'hD1;
    for (int i = 0; i < 4; i++) begin
      bus_start(1'b1, 3'(i), wr_dat[i]);
      check_vec("q_after_mode_write", q, q_exp[i]);
      bus_end();
    end
    bus_read("rd_q_modes", ADR_OUT_TGL, 8'hD1);
    bus_write(ADR_IN, 8'h5A);
    bus_read("rd_in_write_ignored", ADR_IN, 8'h00);

    // ---- rising edge on bit 0, irq latency of SYNC_STAGES+2
    bus_write(ADR_POL, 8'h01);
    bus_write(ADR_IEN, 8'h01);
    pins[0] = 1'b1;
    for (int c = 1; c <= SS + 2; c++) begin
      @(posedge clk); #1;
      check_bit("irq_latency", irq, c == SS + 2);
    end
    bus_read("rd_in_bit0", ADR_IN, 8'h01);
    bus_read("rd_pend_rise", ADR_PEND, 8'h01);
    bus_start(1'b1, ADR_PEND, 8'h01);
    check_bit("irq_held_on_clear_edge", irq, 1'b1);
    bus_end();
    check_bit("irq_fall_after_clear", irq, 1'b0);
    bus_read("rd_pend_cleared", ADR_PEND, 8'h00);

    // ---- falling edge on bit 3 with IEN off, then enable
    bus_write(ADR_POL, 8'h00);
    bus_write(ADR_IEN, 8'h00);
    pins[3] = 1'b1;
    cycles(SS + 3);
    bus_read("rd_pend_rise_ignored", ADR_PEND, 8'h00);
    pins[3] = 1'b0;
    cycles(SS + 3);
    bus_read("rd_pend_fall", ADR_PEND, 8'h08);
    check_bit("irq_masked", irq, 1'b0);
    bus_write(ADR_IEN, 8'h08);
    check_bit("irq_after_ien", irq, 1'b1);

    // ---- clear and new edge on bit 0 in the same cycle: set wins
    pins[0] = 1'b0;
    repeat (SS) @(posedge clk);
    #1;
    bus_start(1'b1, ADR_PEND, 8'h01);
    bus_end();
    bus_read("rd_pend_set_wins", ADR_PEND, 8'h09);
    bus_write(ADR_PEND, 8'h09);
    bus_read("rd_pend_all_clear", ADR_PEND, 8'h00);
    check_bit("irq_after_all_clear", irq, 1'b0);

    // ---- asynchronous reset mid-cycle with an access pending
    bus_write(ADR_OUT_WR, 8'hFF);
    check_vec("q_ff", q, 8'hFF);
    stb = 1'b1; we = 1'b1; adr = ADR_OUT_WR; dat = 8'h55;
    #2;
    res_n = 1'b0;
    #1;
    check_vec("async_rst_q", q, 8'h00);
    check_bit("async_rst_ack", ack, 1'b0);
    check_bit("async_rst_irq", irq, 1'b0);
    @(posedge clk); #1;
    check_vec("rst_held_q", q, 8'h00);
    stb = 1'b0; we = 1'b0; dat = '0;
    res_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_bit("no_ack_after_release", ack, 1'b0);
    end
    bus_read("rd_post_rst_q", ADR_OUT_WR, 8'h00);
    bus_read("rd_post_rst_ien", ADR_IEN, 8'h00);

    // ---- randomized traffic against the register-semantics model
    m_q = '0; m_ien = '0; m_pol = '0; m_pend = '0; m_pins = '0;
    for (int it = 0; it < 80; it++) begin
      int op;
      logic [2:0]   a;
      logic [W-1:0] d;
      logic [W-1:0] e;
      op = int'($urandom_range(0, 3));
      a  = 3'($urandom_range(0, 7));
      d  = W'($urandom());
      if (op <= 1) begin
        bus_write(a, d);
        case (a)
          3'd0: m_q = d;
          3'd1: m_q = m_q | d;
          3'd2: m_q = m_q & ~d;
          3'd3: m_q = m_q ^ d;
          3'd5: m_ien = d;
          3'd6: m_pend = m_pend & ~d;
          3'd7: m_pol = d;
          default: ;
        endcase
      end else if (op == 2) begin
        case (a)
          3'd4:    e = m_pins;
          3'd5:    e = m_ien;
          3'd6:    e = m_pend;
          3'd7:    e = m_pol;
          default: e = m_q;
        endcase
        bus_read("rand_read", a, e);
      end else begin
        // A bit becomes pending when it moves to the level its polarity selects
        for (int i = 0; i < W; i++)
          if (d[i] != m_pins[i] && d[i] == m_pol[i]) m_pend[i] = 1'b1;
        pins   = d;
        m_pins = d;
        cycles(SS + 3);
      end
      check_vec("rand_q", q, m_q);
      check_bit("rand_irq", irq, |(m_pend & m_ien));
    end
    bus_read("rand_final_pend", ADR_PEND, m_pend);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
